// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - up/down modulo counter with load, prescaler, wrap-or-saturate and tc/wrap status
module updown_counter #(
    parameter int WIDTH     = 5,
    parameter int MAX_VAL   = 31,
    parameter int RESET_VAL = MAX_VAL,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W  = WIDTH'(RESET_VAL);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam bit               SAT      = (SATURATE != 0);

    generate
        if (MAX_VAL < 0 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
            $error("updown_counter: MAX_VAL out of range for WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
            $error("updown_counter: RESET_VAL must be within 0..MAX_VAL");
        end
        if (PRESCALE < 1) begin : g_bad_pre
            $error("updown_counter: PRESCALE must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             at_bound;

    // Boundary depends on the live direction, so tc follows up_dn with no latency.
    assign at_bound = up_dn ? (cnt_q == MAX_W) : (cnt_q == '0);
    assign step     = en && (pre_q == PRE_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = (load_val > MAX_W) ? MAX_W : load_val;
            pre_d = '0;
        end else if (step) begin
            pre_d  = '0;
            wrap_d = at_bound;
            if (at_bound) begin
                if (!SAT) begin
                    cnt_d = up_dn ? '0 : MAX_W;
                end
            end else begin
                cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= RESET_W;
            pre_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = cnt_q;
    assign tc   = at_bound;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed-vector bench for updown_counter across five parameter sets
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [4:0] load_val;

    logic [4:0] o [5];
    logic       t [5];
    logic       w [5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: saturating, 2: MAX_VAL=20, 3: MAX_VAL=9 RESET_VAL=0, 4: PRESCALE=4
    updown_counter u_def (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out(o[0]), .tc(t[0]), .wrap(w[0]));
    updown_counter #(.SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out(o[1]), .tc(t[1]), .wrap(w[1]));
    updown_counter #(.MAX_VAL(20)) u_m20 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out(o[2]), .tc(t[2]), .wrap(w[2]));
    updown_counter #(.MAX_VAL(9), .RESET_VAL(0)) u_m9 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out(o[3]), .tc(t[3]), .wrap(w[3]));
    updown_counter #(.PRESCALE(4)) u_pre (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out(o[4]), .tc(t[4]), .wrap(w[4]));

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic [4:0] load_val;
        int         sel;
        int         exp_out;
        logic       exp_tc;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic u, logic l, logic [4:0] lv, int s,
                                int eo, logic et, logic ew);
        vec_t v;
        v.en = e; v.up_dn = u; v.load = l; v.load_val = lv; v.sel = s;
        v.exp_out = eo; v.exp_tc = et; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input int s, input int eo, input logic et, input logic ew);
        chk({nm, ".out"},  32'(o[s]), 32'(eo));
        chk({nm, ".tc"},   32'(t[s]), 32'(et));
        chk({nm, ".wrap"}, 32'(w[s]), 32'(ew));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_o;
        int prev;

        // Saturating hold at 0: wrap pulses on each step taken at the boundary.
        vecs.push_back(mk(1, 0, 1,  2, 1, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0,  0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,  0, 1, 0, 1, 0));
        // Load clamps to MAX_VAL and beats a step.
        vecs.push_back(mk(0, 0, 1, 25, 2, 20, 0, 0));
        vecs.push_back(mk(1, 0, 1,  7, 2, 7, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 2, 6, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 2, 5, 0, 0));
        // Modulo-10 up count, then direction flip at 1.
        vecs.push_back(mk(1, 1, 1,  0, 3, 0, 0, 0));
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(1, 1, 0, 0, 3, k, (k == 9), 0));
        vecs.push_back(mk(1, 1, 0,  0, 3, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0,  0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 3, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0,  0, 3, 9, 0, 1));

        reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
        #1;
        chk_all("reset_def", 0, 31, 0, 0);
        chk_all("reset_m9",  3, 0, 1, 0);
        #9;
        reset = 1'b0; en = 1'b1; up_dn = 1'b0;

        exp_o = 31;
        for (int i = 0; i < 40; i++) begin
            tick();
            prev  = exp_o;
            exp_o = (prev == 0) ? 31 : prev - 1;
            chk_all($sformatf("down_wrap[%0d]", i), 0, exp_o, (exp_o == 0), (prev == 0));
        end

        foreach (vecs[i]) begin
            en = vecs[i].en; up_dn = vecs[i].up_dn; load = vecs[i].load; load_val = vecs[i].load_val;
            tick();
            chk_all($sformatf("vec[%0d]", i), vecs[i].sel, vecs[i].exp_out, vecs[i].exp_tc, vecs[i].exp_wrap);
        end
        load = 1'b0;

        // Prescale 4: step on every 4th enabled cycle; a 3-cycle en gap delays it by 3.
        en = 1'b0; up_dn = 1'b0; load = 1'b1; load_val = 5'd10;
        tick();
        load = 1'b0; en = 1'b1;
        chk("pre_load", 32'(o[4]), 32'd10);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("pre_run[%0d]", k), 32'(o[4]), (k >= 4) ? 32'd9 : 32'd10);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pre_gap[%0d]", k), 32'(o[4]), 32'd9);
        end
        en = 1'b1;
        tick();
        chk("pre_resume0", 32'(o[4]), 32'd9);
        tick();
        chk("pre_resume1", 32'(o[4]), 32'd8);
        chk("pre_resume1_wrap", 32'(w[4]), 32'd0);

        // Asynchronous reset 2 ns after an edge takes effect before the next edge.
        load = 1'b1; load_val = 5'd12;
        tick();
        load = 1'b0;
        chk("async_pre", 32'(o[0]), 32'd12);
        #1;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 31, 0, 0);
        tick();
        chk_all("async_held", 0, 31, 0, 0);
        #4;
        reset = 1'b0;
        tick();
        chk_all("async_rel0", 0, 30, 0, 0);
        tick();
        chk_all("async_rel1", 0, 29, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
